// File: rtl/change_dispenser.sv
// Coin-hopper controller: queues owed $10 coins and runs the hopper
// motor one coin at a time, flagging a jam when no coin drops.
module change_dispenser #(
   parameter int TIMEOUT    = 1000,
   parameter int GAP_CYCLES = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       change_return,
   input  logic       coin_sensor,
   input  logic       clear_jam,
   output logic       hopper_drive,
   output logic [3:0] pending,
   output logic [7:0] coins_paid,
   output logic       busy,
   output logic       jam,
   output logic       overflow
);

   localparam int TMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] G_LAST = TW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      GAP,
      JAM
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_n;
   logic [3:0]    pend_n;
   logic [7:0]    paid_n;
   logic          ovf_n;
   logic          s1;
   logic          s2;
   logic          s3;
   logic          coin_edge;
   logic          accept;

   // Synchronise the raw exit sensor; s3 only serves edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= coin_sensor;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign coin_edge = s2 & ~s3;
   assign accept    = coin_edge && (state == DRIVE);

   // Pending queue, paid total and sticky drop flag
   always_comb begin
      pend_n = pending;
      paid_n = coins_paid;
      ovf_n  = overflow;
      if (clear_jam) ovf_n = 1'b0;
      if (change_return && !accept) begin
         if (pending == 4'hf) ovf_n = 1'b1;
         else pend_n = pending + 4'd1;
      end else if (accept && !change_return && pending != 4'd0) begin
         pend_n = pending - 4'd1;
      end
      if (accept) paid_n = coins_paid + 8'd1;
   end

   // Motor sequencing; a coin seen on the timeout cycle still counts
   always_comb begin
      state_n = state;
      timer_n = timer;
      unique case (state)
         IDLE: begin
            timer_n = '0;
            if (pending != 4'd0) state_n = DRIVE;
         end
         DRIVE: begin
            timer_n = timer + TW'(1);
            if (coin_edge) begin
               state_n = GAP;
               timer_n = '0;
            end else if (timer == T_LAST) begin
               state_n = JAM;
               timer_n = '0;
            end
         end
         GAP: begin
            if (timer == G_LAST) begin
               state_n = (pending != 4'd0) ? DRIVE : IDLE;
               timer_n = '0;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         JAM: begin
            timer_n = '0;
            if (clear_jam) state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            timer_n = '0;
         end
      endcase
   end

   // State, counters and registered outputs derived from next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         timer        <= '0;
         pending      <= 4'd0;
         coins_paid   <= 8'd0;
         overflow     <= 1'b0;
         hopper_drive <= 1'b0;
         jam          <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_n;
         timer        <= timer_n;
         pending      <= pend_n;
         coins_paid   <= paid_n;
         overflow     <= ovf_n;
         hopper_drive <= (state_n == DRIVE);
         jam          <= (state_n == JAM);
         busy         <= (state_n != IDLE) || (pend_n != 4'd0);
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed stimulus, drive/jam edge
// events checked against a queue of hand-computed expectations.
module tb_change_dispenser;

   localparam int K_RISE  = 0;
   localparam int K_FALL  = 1;
   localparam int K_JRISE = 2;
   localparam int K_JFALL = 3;

   typedef struct {
      string name;
      int    kind;
      int    dt;
      int    pend;
      int    paid;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       change_return;
   logic       coin_sensor;
   logic       clear_jam;
   logic       hopper_drive;
   logic [3:0] pending;
   logic [7:0] coins_paid;
   logic       busy;
   logic       jam;
   logic       overflow;

   exp_t sb[$];
   int   checks;
   int   errors;
   int   cyc;
   int   last_cyc;
   logic prev_drive;
   logic prev_jam;

   change_dispenser #(
      .TIMEOUT   (20),
      .GAP_CYCLES(3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .change_return(change_return),
      .coin_sensor  (coin_sensor),
      .clear_jam    (clear_jam),
      .hopper_drive (hopper_drive),
      .pending      (pending),
      .coins_paid   (coins_paid),
      .busy         (busy),
      .jam          (jam),
      .overflow     (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic push(input string name, input int kind,
                       input int dt, input int pend, input int paid);
      exp_t e;
      e.name = name;
      e.kind = kind;
      e.dt   = dt;
      e.pend = pend;
      e.paid = paid;
      sb.push_back(e);
   endtask

   task automatic note_event(input int kind);
      exp_t e;
      int   dt;
      dt       = cyc - last_cyc;
      last_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event kind=%0d cyc=%0d", kind, cyc);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind ||
             (e.dt >= 0 && e.dt != dt) ||
             (e.pend >= 0 && e.pend != int'(pending)) ||
             (e.paid >= 0 && e.paid != int'(coins_paid))) begin
            errors++;
            $display("FAIL %s got kind=%0d dt=%0d pend=%0d paid=%0d want kind=%0d dt=%0d pend=%0d paid=%0d",
                     e.name, kind, dt, pending, coins_paid,
                     e.kind, e.dt, e.pend, e.paid);
         end
      end
   endtask

   // Monitor: any edge of hopper_drive or jam consumes one expectation
   initial begin
      prev_drive = 1'b0;
      prev_jam   = 1'b0;
      last_cyc   = 0;
      forever begin
         @(negedge clk);
         if (hopper_drive !== prev_drive)
            note_event(hopper_drive ? K_RISE : K_FALL);
         if (jam !== prev_jam)
            note_event(jam ? K_JRISE : K_JFALL);
         prev_drive = hopper_drive;
         prev_jam   = jam;
      end
   end

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic wait_out(input bit is_jam, input logic v, input string name);
      int n;
      n = 0;
      while ((is_jam ? jam : hopper_drive) !== v && n < 200) begin
         @(negedge clk);
         n++;
      end
      if ((is_jam ? jam : hopper_drive) !== v) begin
         checks++;
         errors++;
         $display("FAIL %s timed out got %0b want %0b", name,
                  is_jam ? jam : hopper_drive, v);
      end
   endtask

   task automatic pulse_cr(input int n);
      change_return = 1'b1;
      repeat (n) @(negedge clk);
      change_return = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_jam = 1'b1;
      @(negedge clk);
      clear_jam = 1'b0;
   endtask

   task automatic sense_pulse();
      coin_sensor = 1'b1;
      repeat (2) @(negedge clk);
      coin_sensor = 1'b0;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      reset         = 1'b0;
      change_return = 1'b0;
      coin_sensor   = 1'b0;
      clear_jam     = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_drive", hopper_drive, 0);
      check("rst_pending", pending, 0);
      check("rst_paid", coins_paid, 0);
      check("rst_busy", busy, 0);
      check("rst_jam", jam, 0);
      check("rst_ovf", overflow, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Normal dispense of three coins
      push("n_rise1", K_RISE, -1, -1, -1);
      push("n_fall1", K_FALL, 9, 2, 1);
      push("n_rise2", K_RISE, 3, -1, -1);
      push("n_fall2", K_FALL, 8, 1, 2);
      push("n_rise3", K_RISE, 3, -1, -1);
      push("n_fall3", K_FALL, 8, 0, 3);
      pulse_cr(3);
      for (int i = 0; i < 3; i++) begin
         wait_out(1'b0, 1'b1, "n_wait_rise");
         repeat (5) @(negedge clk);
         sense_pulse();
         wait_out(1'b0, 1'b0, "n_wait_fall");
      end
      repeat (2) @(negedge clk);
      check("n_busy_gap", busy, 1);
      @(negedge clk);
      check("n_busy_end", busy, 0);
      check("n_paid", coins_paid, 3);

      // Jam with sensor held low, spurious sensor while jammed
      push("j_rise", K_RISE, -1, -1, -1);
      push("j_fall", K_FALL, 20, 1, 3);
      push("j_jrise", K_JRISE, 0, 1, 3);
      pulse_cr(1);
      wait_out(1'b1, 1'b1, "j_wait_jam");
      sense_pulse();
      repeat (4) @(negedge clk);
      check("j_pending", pending, 1);
      check("j_paid", coins_paid, 3);
      check("j_jam", jam, 1);

      // Clear jam, then coin together with change_return, then coin
      // landing on the last timeout cycle
      push("c_jfall", K_JFALL, -1, 1, 3);
      push("c_rise", K_RISE, 1, -1, -1);
      push("s_fall", K_FALL, 8, 1, 4);
      push("s_rise", K_RISE, 3, -1, -1);
      push("t_fall", K_FALL, 20, 0, 5);
      pulse_clear();
      wait_out(1'b0, 1'b1, "c_wait_rise");
      repeat (5) @(negedge clk);
      coin_sensor = 1'b1;
      repeat (2) @(negedge clk);
      coin_sensor   = 1'b0;
      change_return = 1'b1;
      @(negedge clk);
      change_return = 1'b0;
      wait_out(1'b0, 1'b0, "s_wait_fall");
      wait_out(1'b0, 1'b1, "t_wait_rise");
      repeat (17) @(negedge clk);
      sense_pulse();
      wait_out(1'b0, 1'b0, "t_wait_fall");
      sense_pulse();
      repeat (4) @(negedge clk);
      check("g_pending", pending, 0);
      check("g_paid", coins_paid, 5);
      check("g_jam", jam, 0);
      check("g_busy", busy, 0);

      // Asynchronous reset mid-DRIVE
      push("r_rise", K_RISE, -1, -1, -1);
      push("r_fall", K_FALL, -1, 0, 0);
      pulse_cr(3);
      check("r_pending_pre", pending, 3);
      check("r_drive_pre", hopper_drive, 1);
      #2 reset = 1'b0;
      #1;
      check("r_drive", hopper_drive, 0);
      check("r_pending", pending, 0);
      check("r_paid", coins_paid, 0);
      check("r_jam", jam, 0);
      check("r_ovf", overflow, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("r_busy_after", busy, 0);
      check("r_drive_after", hopper_drive, 0);

      // Overflow: 17 back-to-back pulses
      push("o_rise", K_RISE, -1, -1, -1);
      push("o_fall", K_FALL, 20, 15, 0);
      push("o_jrise", K_JRISE, 0, 15, 0);
      pulse_cr(17);
      check("o_pending", pending, 15);
      check("o_ovf", overflow, 1);
      pulse_clear();
      check("o_ovf_clr", overflow, 0);
      check("o_pending_clr", pending, 15);
      check("o_drive_kept", hopper_drive, 1);
      check("o_jam_kept", jam, 0);
      wait_out(1'b1, 1'b1, "o_wait_jam");
      push("o_jfall", K_JFALL, -1, 15, 0);
      push("o_rise2", K_RISE, 1, -1, -1);
      push("o_rfall", K_FALL, -1, 0, 0);
      pulse_clear();
      wait_out(1'b0, 1'b1, "o_wait_rise");
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
